// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller for the F/D/E/M/W core: operand forwarding, load-use
// bubbles, multi-cycle execute stalls, taken-branch flushes and a stall-cycle counter.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no hazard in flight; decode forwarding/load-use/branch/mc start
// LOAD_WAIT  | extra load-use bubbles beyond the first (LOAD_LAT > 1)
// MC_BUSY    | multi-cycle unit owns E; freeze front end until mcDoneE
module hazard_unit_mc #(
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        rstN,
   input  logic [NUM_SRC*REG_AW-1:0]   srcAddrD,
   input  logic [NUM_SRC*REG_AW-1:0]   srcAddrE,
   input  logic [REG_AW-1:0]           rdE,
   input  logic [REG_AW-1:0]           rdM,
   input  logic [REG_AW-1:0]           rdW,
   input  logic                        regWriteE,
   input  logic                        regWriteM,
   input  logic                        regWriteW,
   input  logic                        memReadE,
   input  logic                        mcStartE,
   input  logic                        mcDoneE,
   input  logic                        branchTakenE,
   output logic [NUM_SRC*2-1:0]        fwdE,
   output logic                        stallF,
   output logic                        stallD,
   output logic                        stallE,
   output logic                        flushD,
   output logic                        flushE,
   output logic                        flushM,
   output logic [CNT_W-1:0]            stallCount
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOAD_WAIT = 2'd1,
      S_MC_BUSY   = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  lw_cnt, lw_cnt_nxt;
   logic        load_use;
   logic [CNT_W-1:0] stall_cnt;

   // x0 is hardwired zero, so it is never a forwarding source
   always_comb begin
      fwdE = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if ((srcAddrE[i*REG_AW +: REG_AW] != '0) && regWriteM &&
             (rdM == srcAddrE[i*REG_AW +: REG_AW]))
            fwdE[i*2 +: 2] = 2'b10;
         else if ((srcAddrE[i*REG_AW +: REG_AW] != '0) && regWriteW &&
                  (rdW == srcAddrE[i*REG_AW +: REG_AW]))
            fwdE[i*2 +: 2] = 2'b01;
      end
   end

   always_comb begin
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (srcAddrD[i*REG_AW +: REG_AW] == rdE)
            load_use = 1'b1;
      end
      load_use = load_use & memReadE & regWriteE & (rdE != '0);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state  <= S_IDLE;
         lw_cnt <= 2'd0;
      end else begin
         state  <= state_nxt;
         lw_cnt <= lw_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      lw_cnt_nxt = lw_cnt;
      case (state)
         S_IDLE: begin
            if (mcStartE) begin
               if (!mcDoneE)
                  state_nxt = S_MC_BUSY;
            end else if (branchTakenE) begin
               state_nxt = S_IDLE;
            end else if (load_use && (LOAD_LAT > 1)) begin
               lw_cnt_nxt = 2'(LOAD_LAT - 1);
               state_nxt  = S_LOAD_WAIT;
            end
         end
         S_LOAD_WAIT: begin
            lw_cnt_nxt = lw_cnt - 2'd1;
            if (lw_cnt <= 2'd1)
               state_nxt = S_IDLE;
         end
         S_MC_BUSY: begin
            if (mcDoneE)
               state_nxt = S_IDLE;
         end
         default: begin
            state_nxt  = S_IDLE;
            lw_cnt_nxt = 2'd0;
         end
      endcase
   end

   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      case (state)
         S_IDLE: begin
            if (mcStartE) begin
               if (!mcDoneE) begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  stallE = 1'b1;
                  flushM = 1'b1;
               end
            end else if (branchTakenE) begin
               flushD = 1'b1;
               flushE = 1'b1;
            end else if (load_use) begin
               stallF = 1'b1;
               stallD = 1'b1;
               flushE = 1'b1;
            end
         end
         S_LOAD_WAIT: begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
         S_MC_BUSY: begin
            if (!mcDoneE) begin
               stallF = 1'b1;
               stallD = 1'b1;
               stallE = 1'b1;
               flushM = 1'b1;
            end
         end
         default: begin
            stallF = 1'b0;
         end
      endcase
      // reset must release the pipeline immediately, not at the next edge
      if (!rstN) begin
         stallF = 1'b0;
         stallD = 1'b0;
         stallE = 1'b0;
         flushD = 1'b0;
         flushE = 1'b0;
         flushM = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)
         stall_cnt <= '0;
      else if (stallF && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign stallCount = stall_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share stimulus; a queue of expected responses is checked each cycle.
module tb_hazard_unit_mc;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [9:0]  srcAddrD = '0, srcAddrE = '0;
   logic [4:0]  rdE = '0, rdM = '0, rdW = '0;
   logic        regWriteE = 0, regWriteM = 0, regWriteW = 0;
   logic        memReadE = 0, mcStartE = 0, mcDoneE = 0, branchTakenE = 0;

   logic [3:0]  fwd_a, fwd_b;
   logic        sf_a, sd_a, se_a, fd_a, fe_a, fm_a;
   logic        sf_b, sd_b, se_b, fd_b, fe_b, fm_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   always #5 clk = ~clk;

   hazard_unit_mc #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) dut_a (
      .clk(clk), .rstN(rstN), .srcAddrD(srcAddrD), .srcAddrE(srcAddrE),
      .rdE(rdE), .rdM(rdM), .rdW(rdW),
      .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
      .memReadE(memReadE), .mcStartE(mcStartE), .mcDoneE(mcDoneE),
      .branchTakenE(branchTakenE), .fwdE(fwd_a),
      .stallF(sf_a), .stallD(sd_a), .stallE(se_a),
      .flushD(fd_a), .flushE(fe_a), .flushM(fm_a), .stallCount(cnt_a));

   hazard_unit_mc #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(4)) dut_b (
      .clk(clk), .rstN(rstN), .srcAddrD(srcAddrD), .srcAddrE(srcAddrE),
      .rdE(rdE), .rdM(rdM), .rdW(rdW),
      .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
      .memReadE(memReadE), .mcStartE(mcStartE), .mcDoneE(mcDoneE),
      .branchTakenE(branchTakenE), .fwdE(fwd_b),
      .stallF(sf_b), .stallD(sd_b), .stallE(se_b),
      .flushD(fd_b), .flushE(fe_b), .flushM(fm_b), .stallCount(cnt_b));

   typedef struct packed {
      logic       rst;
      logic [9:0] src_d;
      logic [9:0] src_e;
      logic [4:0] rd_e, rd_m, rd_w;
      logic       we_e, we_m, we_w, mem_rd, mc_start, mc_done, br;
   } stim_t;

   typedef struct {
      string       nm;
      logic [3:0]  fwd;
      logic [5:0]  ca, cb;
      logic [15:0] na;
      logic [3:0]  nb;
   } exp_t;

   // control vector order: {stallF, stallD, stallE, flushD, flushE, flushM}
   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_LU   = 6'b110010;
   localparam logic [5:0] C_MC   = 6'b111001;
   localparam logic [5:0] C_BR   = 6'b000110;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   stim_t s;

   function automatic stim_t idle();
      stim_t r;
      r = '0;
      r.rst = 1'b1;
      return r;
   endfunction

   task automatic step(input string nm, input stim_t st, input logic [3:0] f,
                       input logic [5:0] ca, input logic [5:0] cb,
                       input int na, input int nb);
      exp_t e;
      @(posedge clk);
      #1;
      rstN = st.rst;
      srcAddrD = st.src_d;  srcAddrE = st.src_e;
      rdE = st.rd_e;        rdM = st.rd_m;        rdW = st.rd_w;
      regWriteE = st.we_e;  regWriteM = st.we_m;  regWriteW = st.we_w;
      memReadE = st.mem_rd; mcStartE = st.mc_start;
      mcDoneE = st.mc_done; branchTakenE = st.br;
      e.nm = nm; e.fwd = f; e.ca = ca; e.cb = cb;
      e.na = 16'(na); e.nb = 4'(nb);
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (fwd_a !== e.fwd) begin
            errors++;
            $display("FAIL %s fwd_a got %b want %b", e.nm, fwd_a, e.fwd);
         end
         checks++;
         if (fwd_b !== e.fwd) begin
            errors++;
            $display("FAIL %s fwd_b got %b want %b", e.nm, fwd_b, e.fwd);
         end
         checks++;
         if ({sf_a, sd_a, se_a, fd_a, fe_a, fm_a} !== e.ca) begin
            errors++;
            $display("FAIL %s ctl_a got %b want %b", e.nm,
                     {sf_a, sd_a, se_a, fd_a, fe_a, fm_a}, e.ca);
         end
         checks++;
         if ({sf_b, sd_b, se_b, fd_b, fe_b, fm_b} !== e.cb) begin
            errors++;
            $display("FAIL %s ctl_b got %b want %b", e.nm,
                     {sf_b, sd_b, se_b, fd_b, fe_b, fm_b}, e.cb);
         end
         checks++;
         if (cnt_a !== e.na) begin
            errors++;
            $display("FAIL %s cnt_a got %0d want %0d", e.nm, cnt_a, e.na);
         end
         checks++;
         if (cnt_b !== e.nb) begin
            errors++;
            $display("FAIL %s cnt_b got %0d want %0d", e.nm, cnt_b, e.nb);
         end
      end
   end

   initial begin
      // reset and idle
      s = idle(); s.rst = 1'b0;
      step("rst", s, 4'b0000, C_NONE, C_NONE, 0, 0);
      step("idle", idle(), 4'b0000, C_NONE, C_NONE, 0, 0);

      // forwarding
      s = idle(); s.src_e = {5'd5, 5'd5}; s.rd_m = 5'd5; s.we_m = 1; s.rd_w = 5'd5; s.we_w = 1;
      step("fwd_m", s, 4'b1010, C_NONE, C_NONE, 0, 0);
      s.we_m = 0;
      step("fwd_w", s, 4'b0101, C_NONE, C_NONE, 0, 0);
      s.we_m = 1; s.rd_m = 5'd0; s.rd_w = 5'd0;
      step("fwd_rd0", s, 4'b0000, C_NONE, C_NONE, 0, 0);
      s = idle(); s.src_e = {5'd7, 5'd5}; s.rd_m = 5'd7; s.rd_w = 5'd7; s.we_w = 1;
      step("fwd_op1", s, 4'b0100, C_NONE, C_NONE, 0, 0);
      s = idle(); s.src_e = {5'd5, 5'd9}; s.rd_m = 5'd9; s.we_m = 1; s.rd_w = 5'd5;
      step("fwd_wgate", s, 4'b0010, C_NONE, C_NONE, 0, 0);
      s = idle(); s.rd_m = 5'd0; s.we_m = 1; s.rd_w = 5'd0; s.we_w = 1;
      step("fwd_x0", s, 4'b0000, C_NONE, C_NONE, 0, 0);

      // load-use, operand 0
      s = idle(); s.mem_rd = 1; s.we_e = 1; s.rd_e = 5'd3; s.src_d = {5'd0, 5'd3};
      step("lu0", s, 4'b0000, C_LU, C_LU, 0, 0);
      step("lu1", idle(), 4'b0000, C_NONE, C_LU, 1, 1);
      step("lu2", idle(), 4'b0000, C_NONE, C_LU, 1, 2);
      step("lu3", idle(), 4'b0000, C_NONE, C_NONE, 1, 3);
      step("lu4", idle(), 4'b0000, C_NONE, C_NONE, 1, 3);
      s = idle(); s.mem_rd = 1; s.we_e = 1; s.rd_e = 5'd0; s.src_d = {5'd0, 5'd0};
      step("lu_rd0", s, 4'b0000, C_NONE, C_NONE, 1, 3);
      // load-use on operand 1; branch during LOAD_WAIT is ignored by dut_b
      s = idle(); s.mem_rd = 1; s.we_e = 1; s.rd_e = 5'd4; s.src_d = {5'd4, 5'd1};
      step("lu_op1", s, 4'b0000, C_LU, C_LU, 1, 3);
      s = idle(); s.br = 1;
      step("lu_br", s, 4'b0000, C_BR, C_LU, 2, 4);
      step("lu_w2", idle(), 4'b0000, C_NONE, C_LU, 2, 5);
      step("lu_end", idle(), 4'b0000, C_NONE, C_NONE, 2, 6);

      // multi-cycle op, done four cycles after start; branch ignored while busy
      s = idle(); s.mc_start = 1;
      step("mc0", s, 4'b0000, C_MC, C_MC, 2, 6);
      step("mc1", idle(), 4'b0000, C_MC, C_MC, 3, 7);
      s = idle(); s.br = 1;
      step("mc_br", s, 4'b0000, C_MC, C_MC, 4, 8);
      step("mc3", idle(), 4'b0000, C_MC, C_MC, 5, 9);
      s = idle(); s.mc_done = 1;
      step("mc_done", s, 4'b0000, C_NONE, C_NONE, 6, 10);
      step("mc_idle", idle(), 4'b0000, C_NONE, C_NONE, 6, 10);
      s = idle(); s.mc_start = 1; s.mc_done = 1;
      step("mc_1cyc", s, 4'b0000, C_NONE, C_NONE, 6, 10);
      step("mc_1cyc_after", idle(), 4'b0000, C_NONE, C_NONE, 6, 10);

      // branch wins over load-use
      s = idle(); s.br = 1; s.mem_rd = 1; s.we_e = 1; s.rd_e = 5'd3; s.src_d = {5'd0, 5'd3};
      step("br_lu", s, 4'b0000, C_BR, C_BR, 6, 10);
      step("br_after", idle(), 4'b0000, C_NONE, C_NONE, 6, 10);

      // reset in the middle of MC_BUSY
      s = idle(); s.mc_start = 1;
      step("rmc0", s, 4'b0000, C_MC, C_MC, 6, 10);
      step("rmc1", idle(), 4'b0000, C_MC, C_MC, 7, 11);
      s = idle(); s.rst = 1'b0;
      step("rmc_rst", s, 4'b0000, C_NONE, C_NONE, 0, 0);
      step("rmc_rel", idle(), 4'b0000, C_NONE, C_NONE, 0, 0);
      step("rmc_idle", idle(), 4'b0000, C_NONE, C_NONE, 0, 0);

      // counter saturation on the 4-bit instance
      s = idle(); s.mc_start = 1;
      step("sat0", s, 4'b0000, C_MC, C_MC, 0, 0);
      for (int k = 1; k <= 20; k++)
         step("sat", idle(), 4'b0000, C_MC, C_MC, k, (k > 15) ? 15 : k);
      s = idle(); s.mc_done = 1;
      step("sat_done", s, 4'b0000, C_NONE, C_NONE, 21, 15);
      step("sat_hold", idle(), 4'b0000, C_NONE, C_NONE, 21, 15);

      for (int w = 0; w < 10 && sb.size() > 0; w++)
         @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised pipeline hazard controller for the 5-stage F/D/E/M/W core. It succeeds the combinational forwarding/load-use unit. It adds:
- N generic source operands.
- Configurable load-use bubble count.
- A multi-cycle execute-unit stall FSM (mul/div).
- Taken-branch flush.
- A saturating stall-cycle performance counter.

It sits beside the datapath and drives all stall, flush and forward-select controls.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, source operands per instruction
LOAD_LAT, 1, bubbles inserted per load-use hazard (legal 1..3)
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  clock
rstN  in  1  asynchronous active-low reset
srcAddrD  in  NUM_SRC*REG_AW  source register addresses in D (operand i at [i*REG_AW +: REG_AW])
srcAddrE  in  NUM_SRC*REG_AW  source register addresses in E
rdE  in  REG_AW  destination register in E
rdM  in  REG_AW  destination register in M
rdW  in  REG_AW  destination register in W
regWriteE  in  1  E instruction writes rd
regWriteM  in  1  M instruction writes rd
regWriteW  in  1  W instruction writes rd
memReadE  in  1  E instruction is a load
mcStartE  in  1  E holds a multi-cycle op this cycle
mcDoneE  in  1  multi-cycle unit result valid this cycle
branchTakenE  in  1  taken branch/jump resolved in E
fwdE  out  NUM_SRC*2  forward select per operand (00 regfile, 01 W, 10 M)
stallF  out  1  hold PC
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register
flushD  out  1  clear F/D register
flushE  out  1  clear D/E register (bubble)
flushM  out  1  clear E/M register (bubble)
stallCount  out  CNT_W  saturating count of cycles with stallF=1

Behaviour:
- Forwarding (combinational, per operand i):
  - If srcAddrE[i]!=0, regWriteM and rdM==srcAddrE[i]: select 10.
  - Else if srcAddrE[i]!=0, regWriteW and rdW==srcAddrE[i]: select 01.
  - Else: select 00.
  - M has priority over W. The W path is gated by regWriteW, never by regWriteM.
- loadUse = memReadE & regWriteE & (rdE!=0) & (any i: srcAddrD[i]==rdE).
- FSM states: IDLE, LOAD_WAIT, MC_BUSY. Internal counter lwCnt is 2 bits wide.
- IDLE priority is mcStartE > branchTakenE > loadUse:
  - mcStartE & !mcDoneE: stallF=stallD=stallE=1, flushM=1. Next state MC_BUSY.
  - mcStartE & mcDoneE: single-cycle completion. No stall. Stay in IDLE.
  - branchTakenE: flushD=flushE=1, no stall. Stay in IDLE.
  - loadUse: stallF=stallD=1, flushE=1. If LOAD_LAT>1, load lwCnt=LOAD_LAT-1 and go to LOAD_WAIT; else stay in IDLE.
  - Otherwise: all stall/flush outputs 0.
- LOAD_WAIT:
  - stallF=stallD=1, flushE=1.
  - lwCnt decrements each cycle; go to IDLE in the cycle after lwCnt==1.
  - loadUse, branchTakenE and mcStartE are ignored (E holds a bubble).
- MC_BUSY:
  - While !mcDoneE: stallF=stallD=stallE=1, flushM=1.
  - Cycle with mcDoneE: all outputs 0, next state IDLE.
  - branchTakenE is ignored.
- Illegal input combinations (bench must not drive):
  - memReadE together with branchTakenE.
  - memReadE together with mcStartE.
  - If driven anyway, the stated priority governs.
- stallCount:
  - Increments on every clock edge where stallF=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Reset clears it to 0.
- Reset (rstN=0, asynchronous):
  - state=IDLE, lwCnt=0, stallCount=0.
  - stall/flush outputs are forced to 0 while rstN=0.
  - fwdE stays combinational.
  - Asserting reset mid-LOAD_WAIT or mid-MC_BUSY abandons the stall immediately. Normal operation resumes in the first cycle after deassertion.
- Latency:
  - Hazard outputs are combinational from state and inputs in the same cycle.
  - State and counter updates are registered on the rising edge of clk.

Test Plan:
- Forwarding: srcAddrE={5,5}, rdM=5, regWriteM=1, rdW=5, regWriteW=1 -> fwdE={10,10}. With regWriteM=0 -> {01,01}. With rdM=rdW=0 -> {00,00}. With regWriteW=1, regWriteM=0, rdM=rdW=7, srcAddrE[1]=7 -> operand 1 selects 01.
- Load-use, LOAD_LAT=1 then LOAD_LAT=3: memReadE=1, regWriteE=1, rdE=3, srcAddrD[0]=3 -> stallF/stallD/flushE high for exactly 1 (resp. 3) cycles. stallCount increases by 1 (resp. 3). With rdE=0 -> no stall.
- Multi-cycle op: mcStartE pulse, mcDoneE raised 4 cycles later -> stallF/stallD/stallE/flushM high for 4 cycles, low in the mcDoneE cycle, state back to IDLE. mcStartE&mcDoneE in the same cycle -> no stall.
- Branch: branchTakenE=1 while loadUse=1 -> flushD=flushE=1, stallF=0. branchTakenE during MC_BUSY -> ignored, stall continues.
- Reset mid-operation: drop rstN during the second cycle of MC_BUSY -> all stall/flush outputs 0 immediately and stallCount=0. After release with idle inputs -> all outputs 0.
- Saturation with CNT_W=4: hold MC_BUSY for 20 cycles -> stallCount stops at 15.
